pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-stage controller that drives the program counter's `inc`, `branch_en` and `branch_addr` inputs. Each cycle it decides among sequential fetch, stall, redirect (branch/call/return from EX) and interrupt vectoring.
- Owns a small return-address stack (RAS) for calls and interrupts.
- Generates the pipeline flush pulse for wrong-path instructions.

Parameters:
- ADDR_W, 11, address width; matches the PC.
- RAS_DEPTH, 4, return-address stack entries (power of 2, 2..16).
- IRQ_VECTOR, 11'h7F0, interrupt service entry address.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_current  in  ADDR_W  PC value currently being fetched
- stall_req  in  1  hazard unit: hold PC this cycle
- br_taken  in  1  EX: conditional/unconditional branch taken
- br_target  in  ADDR_W  branch destination
- call_req  in  1  EX: subroutine call
- call_target  in  ADDR_W  call destination
- call_link  in  ADDR_W  return address to push (call instr + 1)
- ret_req  in  1  EX: subroutine return
- reti_req  in  1  EX: return from interrupt
- irq_req  in  1  level interrupt request, held until irq_ack
- irq_en  in  1  global interrupt enable
- halt_req  in  1  EX: halt instruction
- pc_inc  out  1  to PC `inc`
- pc_branch_en  out  1  to PC `branch_en`
- pc_branch_addr  out  ADDR_W  to PC `branch_addr`
- flush  out  1  kill IF/ID and ID/EX contents
- irq_ack  out  1  one-cycle interrupt accept
- in_isr  out  1  servicing interrupt (nesting masked)
- ras_count  out  clog2(RAS_DEPTH)+1  RAS occupancy
- ras_overflow  out  1  sticky: push while full
- ras_underflow  out  1  sticky: pop while empty
- state  out  2  FSM state (debug)

Behaviour:
- Control outputs `pc_inc`, `pc_branch_en`, `pc_branch_addr`, `flush` and `irq_ack` are combinational from state, inputs and RAS top. The PC updates on the same rising edge, so redirect latency is zero cycles.
- FSM state, RAS, `in_isr` and the sticky flags are registered.
- Reset (`rst_n`=0, async):
  - state=BOOT, RAS empty, `ras_count`=0, `in_isr`=0, both sticky flags=0.
  - All outputs 0; `pc_branch_addr`=0 whenever `pc_branch_en`=0.
- States: BOOT=0, RUN=1, HALT=2 (3 unused, decodes to BOOT).
- BOOT: one cycle, `pc_inc`=0, all inputs ignored; then RUN.
- RUN priority (highest first; exactly one action per cycle):
  1. `reti_req`:
     - Pop → `pc_branch_en`=1, addr=RAS top, `flush`=1, `in_isr`←0.
     - If RAS empty: no redirect, `pc_inc`=1, `ras_underflow`←1, `in_isr`←0.
  2. `ret_req`: same as `reti_req` but `in_isr` unchanged.
  3. `call_req`:
     - Push `call_link`; `pc_branch_en`=1, addr=`call_target`, `flush`=1.
     - If RAS full: push dropped, `ras_overflow`←1, branch still taken.
  4. `br_taken`: `pc_branch_en`=1, addr=`br_target`, `flush`=1.
  5. `irq_req` & `irq_en` & !`in_isr` & !`stall_req`:
     - Push `pc_current`; `pc_branch_en`=1, addr=IRQ_VECTOR; `flush`=1, `irq_ack`=1, `in_isr`←1.
     - Overflow rule as for calls.
  6. `halt_req`: `pc_inc`=0, next=HALT.
  7. `stall_req`: `pc_inc`=0, nothing else.
  8. Otherwise: `pc_inc`=1.
- Redirects override `stall_req`. An interrupt arriving during a redirect or stall is deferred; `irq_req` stays high until `irq_ack`.
- `pc_inc` and `pc_branch_en` are never both 1.
- HALT:
  - `pc_inc`=0.
  - Leaves on `irq_req` & `irq_en`: push `pc_current`, vector, `irq_ack`, `in_isr`←1, next=RUN.
  - All other inputs ignored; leaves only via interrupt or reset.
- RAS: LIFO, `ras_count` 0..RAS_DEPTH. Only one push or pop per cycle, by the priority order above. The pointer does not wrap.
- Sticky flags clear only on reset.
- Reset mid-redirect: async clear, no partial RAS update survives.

Test Plan:
- Release reset, no requests → cycle 1 `pc_inc`=0 (BOOT); cycles 2..n `pc_inc`=1; PC reads 0,0,1,2,3.
- PC=5, `stall_req`=1 and `br_taken`=1 with `br_target`=0x40 same cycle → `pc_branch_en`=1, `flush`=1, PC=0x40 next cycle.
- Call sequence:
  - `call_req` with target=0x100, link=0x0A → PC=0x100, `ras_count`=1.
  - Later `ret_req` → PC=0x0A, `ras_count`=0.
- Five nested calls with RAS_DEPTH=4 → `ras_overflow`=1, `ras_count`=4. Four rets return the first four links; the fifth ret sets `ras_underflow`=1 and PC increments.
- Interrupt deferral and return:
  - `irq_req`=1, `irq_en`=1 at PC=0x20 during `br_taken` to 0x30 → branch taken first.
  - Next cycle: `irq_ack`=1, PC=0x7F0, RAS top=0x30, `in_isr`=1.
  - A second `irq_req` is ignored while `in_isr`=1.
  - `reti_req` → PC=0x30, `in_isr`=0.
- `halt_req` at PC=0x12 → state=HALT, PC frozen 10 cycles. Then `irq_req` → PC=0x7F0, state=RUN. `rst_n` low mid-HALT → state=BOOT, all flags 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller choosing sequential fetch, stall, redirect or interrupt
// vectoring each cycle, with a return-address stack for calls and interrupts.
module pc_sequencer #(
   parameter int                 ADDR_W     = 11,
   parameter int                 RAS_DEPTH  = 4,
   parameter logic [ADDR_W-1:0]  IRQ_VECTOR = 11'h7F0,
   localparam int                IW         = $clog2(RAS_DEPTH),
   localparam int                CW         = IW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_current,
   input  logic              stall_req,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              call_req,
   input  logic [ADDR_W-1:0] call_target,
   input  logic [ADDR_W-1:0] call_link,
   input  logic              ret_req,
   input  logic              reti_req,
   input  logic              irq_req,
   input  logic              irq_en,
   input  logic              halt_req,
   output logic              pc_inc,
   output logic              pc_branch_en,
   output logic [ADDR_W-1:0] pc_branch_addr,
   output logic              flush,
   output logic              irq_ack,
   output logic              in_isr,
   output logic [CW-1:0]     ras_count,
   output logic              ras_overflow,
   output logic              ras_underflow,
   output logic [1:0]        state
);
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              in_isr_q, in_isr_d, ovf_q, ovf_d, unf_q, unf_d;
   logic              push, pop, take_irq;
   logic [ADDR_W-1:0] push_val, ras_top;
   logic              empty, full;
   assign empty   = cnt_q == '0;
   assign full    = cnt_q == FULL;
   assign ras_top = ras_q[cnt_q[IW-1:0] - IW'(1)];
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ras_d          = ras_q;
      in_isr_d       = in_isr_q;
      ovf_d          = ovf_q;
      unf_d          = unf_q;
      pc_inc         = 1'b0;
      pc_branch_en   = 1'b0;
      pc_branch_addr = '0;
      flush          = 1'b0;
      irq_ack        = 1'b0;
      push           = 1'b0;
      push_val       = '0;
      pop            = 1'b0;
      take_irq       = 1'b0;
      case (state_q)
         RUN: begin
            if (reti_req || ret_req) begin
               pop = 1'b1;
               if (reti_req) in_isr_d = 1'b0;
            end else if (call_req) begin
               push           = 1'b1;
               push_val       = call_link;
               pc_branch_en   = 1'b1;
               pc_branch_addr = call_target;
               flush          = 1'b1;
            end else if (br_taken) begin
               pc_branch_en   = 1'b1;
               pc_branch_addr = br_target;
               flush          = 1'b1;
            end else if (irq_req && irq_en && !in_isr_q && !stall_req) take_irq = 1'b1;
            else if (halt_req) state_d = HALT;
            else pc_inc = !stall_req;
         end
         HALT: begin
            take_irq = irq_req && irq_en;
            state_d  = take_irq ? RUN : HALT;
         end
         default: state_d = RUN;
      endcase
      if (take_irq) begin
         push           = 1'b1;
         push_val       = pc_current;
         pc_branch_en   = 1'b1;
         pc_branch_addr = IRQ_VECTOR;
         flush          = 1'b1;
         irq_ack        = 1'b1;
         in_isr_d       = 1'b1;
      end
      // An empty pop degrades to a plain sequential fetch.
      if (pop) begin
         if (empty) begin
            pc_inc = 1'b1;
            unf_d  = 1'b1;
         end else begin
            pc_branch_en   = 1'b1;
            pc_branch_addr = ras_top;
            flush          = 1'b1;
            cnt_d          = cnt_q - CW'(1);
         end
      end
      if (push) begin
         if (full) ovf_d = 1'b1;
         else begin
            ras_d[cnt_q[IW-1:0]] = push_val;
            cnt_d                = cnt_q + CW'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BOOT;
         ras_q    <= '{default: '0};
         cnt_q    <= '0;
         in_isr_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ras_q    <= ras_d;
         cnt_q    <= cnt_d;
         in_isr_q <= in_isr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end
   assign in_isr        = in_isr_q;
   assign ras_count     = cnt_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
   assign state         = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus against a queue-based model of the sequencer,
// with the bench playing the PC register.
module tb_pc_sequencer;
   localparam int AW = 11;
   localparam logic [AW-1:0] IV = 11'h7F0;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [AW-1:0] pc_current, br_target, call_target, call_link, pc_branch_addr;
   logic stall_req, br_taken, call_req, ret_req, reti_req, irq_req, irq_en, halt_req;
   logic pc_inc, pc_branch_en, flush, irq_ack, in_isr, ras_overflow, ras_underflow;
   logic [2:0] ras_count;
   logic [1:0] state;
   int errors = 0, checks = 0;
   int mode;
   logic [AW-1:0] ras[$];
   bit m_isr, m_ov, m_un;
   logic [AW-1:0] pc = '0;
   assign pc_current = pc;
   always #5 clk = ~clk;
   pc_sequencer #(.ADDR_W(AW), .RAS_DEPTH(4), .IRQ_VECTOR(IV)) dut (
      .clk(clk), .rst_n(rst_n), .pc_current(pc_current), .stall_req(stall_req),
      .br_taken(br_taken), .br_target(br_target), .call_req(call_req),
      .call_target(call_target), .call_link(call_link), .ret_req(ret_req),
      .reti_req(reti_req), .irq_req(irq_req), .irq_en(irq_en), .halt_req(halt_req),
      .pc_inc(pc_inc), .pc_branch_en(pc_branch_en), .pc_branch_addr(pc_branch_addr),
      .flush(flush), .irq_ack(irq_ack), .in_isr(in_isr), .ras_count(ras_count),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .state(state)
   );
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   task automatic clr();
      {stall_req, br_taken, call_req, ret_req, reti_req, irq_req, halt_req} = '0;
      br_target = '0; call_target = '0; call_link = '0;
   endtask
   task automatic model_reset();
      mode = 0; ras.delete(); m_isr = 0; m_ov = 0; m_un = 0; pc = '0;
   endtask
   task automatic chk_reset();
      chk("rst_pc_inc", pc_inc, 0); chk("rst_branch_en", pc_branch_en, 0);
      chk("rst_branch_addr", pc_branch_addr, 0); chk("rst_flush", flush, 0);
      chk("rst_irq_ack", irq_ack, 0); chk("rst_in_isr", in_isr, 0);
      chk("rst_ras_count", ras_count, 0); chk("rst_overflow", ras_overflow, 0);
      chk("rst_underflow", ras_underflow, 0); chk("rst_state", state, 0);
   endtask
   // One clock: called at a falling edge with inputs already applied.
   task automatic step();
      bit inc = 0, ben = 0, fl = 0, ack = 0, go = 0, psh = 0, pp = 0;
      logic [AW-1:0] addr = '0, pv = '0, pc_n;
      #1;
      chk("state", state, mode); chk("in_isr", in_isr, m_isr);
      chk("ras_count", ras_count, ras.size());
      chk("ras_overflow", ras_overflow, m_ov); chk("ras_underflow", ras_underflow, m_un);
      if (mode == 0) mode = 1;
      else if (mode == 2) begin
         if (irq_req && irq_en) begin go = 1; mode = 1; end
      end else if (reti_req || ret_req) begin
         pp = 1;
         if (reti_req) m_isr = 0;
      end else if (call_req) begin psh = 1; pv = call_link; ben = 1; addr = call_target; fl = 1; end
      else if (br_taken) begin ben = 1; addr = br_target; fl = 1; end
      else if (irq_req && irq_en && !m_isr && !stall_req) go = 1;
      else if (halt_req) mode = 2;
      else if (!stall_req) inc = 1;
      if (go) begin psh = 1; pv = pc; ben = 1; addr = IV; fl = 1; ack = 1; m_isr = 1; end
      if (pp) begin
         if (ras.size() == 0) begin inc = 1; m_un = 1; end
         else begin ben = 1; addr = ras.pop_back(); fl = 1; end
      end
      if (psh) begin
         if (ras.size() == 4) m_ov = 1;
         else ras.push_back(pv);
      end
      chk("pc_inc", pc_inc, inc); chk("pc_branch_en", pc_branch_en, ben);
      chk("pc_branch_addr", pc_branch_addr, addr); chk("flush", flush, fl);
      chk("irq_ack", irq_ack, ack);
      pc_n = ben ? addr : inc ? pc + 1'b1 : pc;
      @(posedge clk);
      #1 pc = pc_n;
      @(negedge clk);
   endtask
   task automatic run(input int n);
      repeat (n) step();
   endtask
   initial begin
      logic [AW-1:0] p;
      clr(); irq_en = 1'b0; model_reset();
      repeat (2) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      step(); chk("boot_pc0", pc, 0);
      run(3); chk("seq_pc3", pc, 3);
      run(2);
      stall_req = 1; br_taken = 1; br_target = 11'h040; step(); clr();
      chk("stall_br_pc", pc, 11'h040);
      call_req = 1; call_target = 11'h100; call_link = 11'h00A; step(); clr();
      chk("call_pc", pc, 11'h100); chk("call_cnt", ras_count, 1);
      run(2);
      ret_req = 1; step(); clr();
      chk("ret_pc", pc, 11'h00A); chk("ret_cnt", ras_count, 0);
      for (int i = 0; i < 5; i++) begin
         call_req = 1; call_target = 11'(11'h200 + i * 16); call_link = 11'(11'h011 + i);
         step(); clr(); step();
      end
      chk("nest_ovf", ras_overflow, 1); chk("nest_cnt", ras_count, 4);
      for (int i = 0; i < 4; i++) begin
         ret_req = 1; step(); clr();
         chk("nest_ret_pc", pc, 11'(11'h014 - i));
         step();
      end
      p = pc;
      ret_req = 1; step(); clr();
      chk("unf_pc", pc, 11'(p + 1'b1)); chk("unf_flag", ras_underflow, 1);
      br_taken = 1; br_target = 11'h020; step(); clr();
      irq_en = 1; irq_req = 1; br_taken = 1; br_target = 11'h030; step(); br_taken = 0;
      chk("defer_pc", pc, 11'h030);
      step(); irq_req = 0;
      chk("irq_pc", pc, IV); chk("irq_isr", in_isr, 1); chk("irq_cnt", ras_count, 1);
      step();
      irq_req = 1; run(3); irq_req = 0;
      chk("nested_irq_ignored_pc", pc, 11'h7F4);
      reti_req = 1; step(); clr();
      chk("reti_pc", pc, 11'h030); chk("reti_isr", in_isr, 0);
      br_taken = 1; br_target = 11'h012; step(); clr();
      halt_req = 1; step(); clr();
      chk("halt_state", state, 2);
      br_taken = 1; br_target = 11'h055; call_req = 1; call_target = 11'h066;
      ret_req = 1; stall_req = 1; halt_req = 1;
      run(10); clr();
      chk("halt_frozen_pc", pc, 11'h012);
      irq_req = 1; step(); irq_req = 0;
      chk("halt_irq_pc", pc, IV); chk("halt_irq_state", state, 1);
      halt_req = 1; step(); clr();
      run(2);
      #2 rst_n = 1'b0;
      #1 chk_reset();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      run(3);
      chk("post_reset_pc", pc, 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
